// File: rtl/uart_trans_shift_if.sv
// rtl/uart_trans_shift_if.sv - control-block to transmitter shift-register bus
interface uart_trans_shift_if;
  logic       ctrl_trans_thr_vld;
  logic [7:0] ctrl_trans_shift_data;
  logic [1:0] ctrl_trans_data_length;
  logic       ctrl_trans_stop_length;
  logic       ctrl_trans_parity_en;
  logic       ctrl_trans_parity_bit;
  logic       trans_ctrl_thr_read;
  logic       trans_ctrl_thsr_empty;
  logic       trans_ctrl_busy;

  modport master (
    output ctrl_trans_thr_vld, ctrl_trans_shift_data, ctrl_trans_data_length,
           ctrl_trans_stop_length, ctrl_trans_parity_en, ctrl_trans_parity_bit,
    input  trans_ctrl_thr_read, trans_ctrl_thsr_empty, trans_ctrl_busy
  );

  modport slave (
    input  ctrl_trans_thr_vld, ctrl_trans_shift_data, ctrl_trans_data_length,
           ctrl_trans_stop_length, ctrl_trans_parity_en, ctrl_trans_parity_bit,
    output trans_ctrl_thr_read, trans_ctrl_thsr_empty, trans_ctrl_busy
  );
endinterface

// File: rtl/uart_trans_shift.sv
// rtl/uart_trans_shift.sv - UART transmit shift register and frame sequencer
module uart_trans_shift #(
  parameter int OVERSAMPLE = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              baud_gen_trans_tick,
  uart_trans_shift_if.slave ctrl,
  output logic              uart_sout
);

  // Last tick index of a normal bit period and of the two long stop variants.
  localparam logic [4:0] LP_BIT_LAST    = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] LP_STOP15_LAST = 5'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [4:0] LP_STOP2_LAST  = 5'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [1:0] r_len;
  logic       r_stop;
  logic       r_pen;
  logic       r_par;

  logic [7:0] w_mask;
  logic [7:0] w_masked;
  logic [4:0] w_period_last;
  logic       w_period_done;
  logic [2:0] w_last_bit;
  logic       w_load;

  // Keep only the bits of the THR that belong to the selected word length.
  always_comb begin
    w_mask = 8'hFF;
    case (ctrl.ctrl_trans_data_length)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
    w_masked = ctrl.ctrl_trans_shift_data & w_mask;
  end

  // Period length: only STOP with the long-stop option differs from one bit.
  always_comb begin
    w_period_last = LP_BIT_LAST;
    if (r_state == S_STOP && r_stop) begin
      w_period_last = (r_len == 2'b00) ? LP_STOP15_LAST : LP_STOP2_LAST;
    end
    w_period_done = baud_gen_trans_tick && (r_tick_cnt == w_period_last);
  end

  // Index of the final data bit is 4 + length code (5..8 bits).
  assign w_last_bit = {1'b1, r_len};

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, load strobe and serial line level.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    uart_sout    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (ctrl.ctrl_trans_thr_vld) begin
          w_load       = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        uart_sout = 1'b0;
        if (w_period_done) w_next_state = S_DATA;
      end
      S_DATA: begin
        uart_sout = r_shift[0];
        if (w_period_done && r_bit_cnt == w_last_bit) begin
          w_next_state = r_pen ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        uart_sout = r_par;
        if (w_period_done) w_next_state = S_STOP;
      end
      S_STOP: begin
        if (w_period_done) begin
          if (ctrl.ctrl_trans_thr_vld) begin
            // Chain straight into the next start bit with no idle cycle.
            w_load       = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign ctrl.trans_ctrl_thr_read   = w_load;
  assign ctrl.trans_ctrl_busy       = (r_state != S_IDLE);
  assign ctrl.trans_ctrl_thsr_empty = (r_state == S_IDLE) && !ctrl.ctrl_trans_thr_vld;

  // Frame datapath: snapshot data and configuration on load, then count ticks and shift bits.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_len      <= 2'd0;
      r_stop     <= 1'b0;
      r_pen      <= 1'b0;
      r_par      <= 1'b0;
    end else if (w_load) begin
      r_tick_cnt <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= w_masked;
      r_len      <= ctrl.ctrl_trans_data_length;
      r_stop     <= ctrl.ctrl_trans_stop_length;
      r_pen      <= ctrl.ctrl_trans_parity_en;
      r_par      <= (^w_masked) ^ ~ctrl.ctrl_trans_parity_bit;
    end else if (r_state != S_IDLE && baud_gen_trans_tick) begin
      if (w_period_done) begin
        r_tick_cnt <= 5'd0;
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + 5'd1;
      end
    end
  end

endmodule
